intersection_ctrl: RTL and testbench

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_pkg.sv | 36 +++
 rtl/phase_timer.sv | 30 +++
 rtl/intersection_ctrl.sv | 106 ++++++++++
 tb/tb_intersection_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
// Shared lamp encodings, FSM state encoding and lamp decode helpers for the
// intersection controller.
package intersection_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  // Seven legal states; 3'd7 is the single illegal code and recovers to CLR_B.
  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    CLR_A  = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    CLR_B  = 3'd5,
    WALK   = 3'd6
  } state_e;

  function automatic logic [2:0] ns_lamp(input state_e st);
    logic [2:0] l;
    l = LAMP_RED;
    if (st == NS_GRN)      l = LAMP_GREEN;
    else if (st == NS_YEL) l = LAMP_YELLOW;
    return l;
  endfunction

  function automatic logic [2:0] ew_lamp(input state_e st);
    logic [2:0] l;
    l = LAMP_RED;
    if (st == EW_GRN)      l = LAMP_GREEN;
    else if (st == EW_YEL) l = LAMP_YELLOW;
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: reloads on load, otherwise counts down; done flags zero.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload takes priority; the controller always reloads when done is high,
  // so the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
    if (load) cnt_d = load_val;
  end

  // Count register, reset to the first-phase remaining count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road traffic light controller with pedestrian walk phase inserted after
// an all-red clearance when a request is pending.
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 5,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic             ret_ew_q, ret_ew_d;   // WALK returns to EW_GRN when set
  logic [2:0]       ns_light_q, ew_light_q;
  logic             walk_q, ped_ack_q;
  logic             load, done, enter_walk, req_any;
  logic [CNT_W-1:0] load_val;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // Next state, timer reload value and pending-request bookkeeping
  always_comb begin
    state_d = state_q;
    load    = done;
    req_any = pend_q | ped_req;   // a request on the last clearance cycle still counts
    case (state_q)
      NS_GRN:  if (done) state_d = NS_YEL;
      NS_YEL:  if (done) state_d = CLR_A;
      CLR_A:   if (done) state_d = req_any ? WALK : EW_GRN;
      EW_GRN:  if (done) state_d = EW_YEL;
      EW_YEL:  if (done) state_d = CLR_B;
      CLR_B:   if (done) state_d = req_any ? WALK : NS_GRN;
      WALK:    if (done) state_d = ret_ew_q ? EW_GRN : NS_GRN;
      default: begin
        state_d = CLR_B;
        load    = 1'b1;
      end
    endcase

    enter_walk = (state_d == WALK) && (state_q != WALK);
    ret_ew_d   = enter_walk ? (state_q == CLR_A) : ret_ew_q;

    // Entering WALK absorbs any request seen on that same cycle.
    pend_d = pend_q;
    if (enter_walk)                        pend_d = 1'b0;
    else if ((state_q != WALK) && ped_req) pend_d = 1'b1;

    case (state_d)
      NS_GRN, EW_GRN: load_val = GREEN_LD;
      NS_YEL, EW_YEL: load_val = YELLOW_LD;
      WALK:           load_val = WALK_LD;
      default:        load_val = ALLRED_LD;
    endcase
  end

  // State, flags and outputs registered together from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLR_B;
      pend_q     <= 1'b0;
      ret_ew_q   <= 1'b0;
      ns_light_q <= LAMP_RED;
      ew_light_q <= LAMP_RED;
      walk_q     <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ret_ew_q   <= ret_ew_d;
      ns_light_q <= ns_lamp(state_d);
      ew_light_q <= ew_lamp(state_d);
      walk_q     <= (state_d == WALK);
      ped_ack_q  <= enter_walk;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign ped_ack  = ped_ack_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: default-parameter and all-ones instances,
// table-driven scenarios, hand-written corner sequences and random requests
// checked against a phase-sequence reference model.
module tb_intersection_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_d, ew_d, ns_1, ew_1;
  logic       walk_d, ack_d, walk_1, ack_1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  intersection_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req),
    .ns_light(ns_d), .ew_light(ew_d), .walk(walk_d), .ped_ack(ack_d)
  );

  intersection_ctrl #(
    .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .WALK_CYC(1), .CNT_W(8)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req),
    .ns_light(ns_1), .ew_light(ew_1), .walk(walk_1), .ped_ack(ack_1)
  );

  // Reference model: phase index in the light sequence plus cycles left.
  // Phases 0..5 = NS green, NS yellow, clear A, EW green, EW yellow, clear B;
  // phase 6 = pedestrian walk.
  typedef struct packed {
    int ph;
    int rem;
    int ret;
    bit pend;
    bit ack;
  } mdl_t;

  mdl_t m_def, m_one;

  function automatic int dur(input int ph, input int g, input int y, input int a, input int w);
    if (ph == 0 || ph == 3) return g;
    if (ph == 1 || ph == 4) return y;
    if (ph == 2 || ph == 5) return a;
    return w;
  endfunction

  function automatic mdl_t mreset(input int a);
    mdl_t m;
    m.ph = 5; m.rem = a; m.ret = 0; m.pend = 1'b0; m.ack = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit req,
                                 input int g, input int y, input int a, input int w);
    mdl_t n;
    n = m;
    n.ack = 1'b0;
    if (m.ph != 6 && req) n.pend = 1'b1;
    n.rem = m.rem - 1;
    if (n.rem == 0) begin
      if ((m.ph == 2 || m.ph == 5) && (m.pend || req)) begin
        n.ph = 6; n.ret = (m.ph + 1) % 6; n.pend = 1'b0; n.ack = 1'b1;
      end else if (m.ph == 6) begin
        n.ph = m.ret;
      end else begin
        n.ph = (m.ph + 1) % 6;
      end
      n.rem = dur(n.ph, g, y, a, w);
    end
    return n;
  endfunction

  function automatic logic [5:0] mlamps(input int ph);
    case (ph)
      0:       return {G, R};
      1:       return {Y, R};
      3:       return {R, G};
      4:       return {R, Y};
      default: return {R, R};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_def <= mreset(2);
      m_one <= mreset(1);
    end else begin
      m_def <= mstep(m_def, ped_req, 8, 3, 2, 5);
      m_one <= mstep(m_one, ped_req, 1, 1, 1, 1);
    end
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got timeout, expected event", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Continuous comparison against the model and lamp-conflict assertion
  logic [5:0] exp_d, exp_1;
  always @(negedge clk) begin
    exp_d = mlamps(m_def.ph);
    exp_1 = mlamps(m_one.ph);
    check("mdl_def_ns",   ns_d, exp_d[5:3]);
    check("mdl_def_ew",   ew_d, exp_d[2:0]);
    check("mdl_def_walk", {2'b0, walk_d}, {2'b0, (m_def.ph == 6)});
    check("mdl_def_ack",  {2'b0, ack_d},  {2'b0, m_def.ack});
    check("mdl_one_ns",   ns_1, exp_1[5:3]);
    check("mdl_one_ew",   ew_1, exp_1[2:0]);
    check("mdl_one_walk", {2'b0, walk_1}, {2'b0, (m_one.ph == 6)});
    check("mdl_one_ack",  {2'b0, ack_1},  {2'b0, m_one.ack});
    checks += 2;
    assert (ns_d == R || ew_d == R) else begin
      errors++;
      $display("FAIL def_conflict: got ns=%b ew=%b, expected at least one RED", ns_d, ew_d);
    end
    assert (ns_1 == R || ew_1 == R) else begin
      errors++;
      $display("FAIL one_conflict: got ns=%b ew=%b, expected at least one RED", ns_1, ew_1);
    end
  end

  typedef struct packed {
    logic       req;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    logic [7:0] n;
  } seg_t;

  seg_t tbl [0:15];
  int   cnt, k;

  initial begin
    // Release from reset, one idle period, then a request pulse in NS green
    tbl[0]  = '{1'b0, R, R, 1'b0, 8'd2};
    tbl[1]  = '{1'b0, G, R, 1'b0, 8'd8};
    tbl[2]  = '{1'b0, Y, R, 1'b0, 8'd3};
    tbl[3]  = '{1'b0, R, R, 1'b0, 8'd2};
    tbl[4]  = '{1'b0, R, G, 1'b0, 8'd8};
    tbl[5]  = '{1'b0, R, Y, 1'b0, 8'd3};
    tbl[6]  = '{1'b0, R, R, 1'b0, 8'd2};
    tbl[7]  = '{1'b1, G, R, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, G, R, 1'b0, 8'd7};
    tbl[9]  = '{1'b0, Y, R, 1'b0, 8'd3};
    tbl[10] = '{1'b0, R, R, 1'b0, 8'd2};
    tbl[11] = '{1'b0, R, R, 1'b1, 8'd5};
    tbl[12] = '{1'b0, R, G, 1'b0, 8'd8};
    tbl[13] = '{1'b0, R, Y, 1'b0, 8'd3};
    tbl[14] = '{1'b0, R, R, 1'b0, 8'd2};
    tbl[15] = '{1'b0, G, R, 1'b0, 8'd8};

    step(3);
    check("rst_ns",   ns_d, R);
    check("rst_ew",   ew_d, R);
    check("rst_walk", {2'b0, walk_d}, 3'b000);
    check("rst_ack",  {2'b0, ack_d},  3'b000);

    rst_n = 1'b1;
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < int'(tbl[s].n); c++) begin
        ped_req = tbl[s].req;
        check("tbl_ns",   ns_d, tbl[s].ns);
        check("tbl_ew",   ew_d, tbl[s].ew);
        check("tbl_walk", {2'b0, walk_d}, {2'b0, tbl[s].wk});
        check("tbl_ack",  {2'b0, ack_d},  {2'b0, (tbl[s].wk && c == 0)});
        step(1);
      end
    end
    ped_req = 1'b0;

    // Request on the last CLR_B cycle, held into the first WALK cycle
    cnt = 0;
    while (!(m_def.ph == 5 && m_def.rem == 1) && cnt < 100) begin step(1); cnt++; end
    if (cnt >= 100) timeout("wait_clrb_last");
    ped_req = 1'b1;
    step(1);
    check("clrb_walk1", {2'b0, walk_d}, 3'b001);
    check("clrb_ack1",  {2'b0, ack_d},  3'b001);
    step(1);
    ped_req = 1'b0;
    check("clrb_walk2", {2'b0, walk_d}, 3'b001);
    check("clrb_ack2",  {2'b0, ack_d},  3'b000);
    step(3);
    check("clrb_walk5", {2'b0, walk_d}, 3'b001);
    step(1);
    check("clrb_ns_grn", ns_d, G);
    check("clrb_walk_off", {2'b0, walk_d}, 3'b000);
    step(13);
    check("no_second_walk_ew", ew_d, G);
    check("no_second_walk", {2'b0, walk_d}, 3'b000);

    // Asynchronous reset in the third WALK cycle
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    cnt = 0;
    while (!ack_d && cnt < 100) begin step(1); cnt++; end
    if (cnt >= 100) timeout("wait_walk_ack");
    step(2);
    check("pre_rst_walk", {2'b0, walk_d}, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ns",   ns_d, R);
    check("arst_ew",   ew_d, R);
    check("arst_walk", {2'b0, walk_d}, 3'b000);
    check("arst_ack",  {2'b0, ack_d},  3'b000);
    step(2);
    rst_n = 1'b1;
    check("rel_red1_ns", ns_d, R);
    check("rel_red1_ew", ew_d, R);
    step(1);
    check("rel_red2_ns", ns_d, R);
    step(1);
    check("rel_ns_grn", ns_d, G);
    check("rel_walk",   {2'b0, walk_d}, 3'b000);
    step(8);
    check("rel_ns_yel", ns_d, Y);

    // Request held high: two walks per 36-cycle period, never stalling
    ped_req = 1'b1;
    step(40);
    k = 0;
    repeat (144) begin
      if (ack_d) k++;
      step(1);
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL held_req_acks: got %0d, expected 8", k);
    end
    ped_req = 1'b0;

    // Random sparse and bursty requests against the model
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) ped_req = ($urandom_range(0, 1) == 1);
      else                           ped_req = ($urandom_range(0, 99) < 5);
      step(1);
    end
    ped_req = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
